// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage of the single-cycle MIPS core.
// Owns the PC, fetches one word at a time over a req/ready handshake, holds it
// for the decoder and, once execute reports completion, advances the PC using
// the resolved jr / jump / branch information.
//
// Optional build macro:
//   FETCH_ALIGN_CHECK_EN - a jr to a non-word-aligned target redirects to
//                          EXC_VECTOR and pulses misalign_exc for one cycle.
//                          Without it the jr target's low two bits are
//                          dropped and misalign_exc is tied low.
module fetch_unit #(
  // PC after reset; must be word-aligned.
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  // Redirect target for a misaligned jr (optional feature only).
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0080
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [5:0]  funct,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        instr_done,
  input  logic        branch_beq,
  input  logic        branch_bne,
  input  logic        alu_zero,
  input  logic [31:0] rs_value,
  output logic        misalign_exc
);

  // MIPS encodings needed to pick the next PC.
  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] FUNCT_JR   = 6'b001000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // one settling cycle after reset
    REQ  = 2'd1,  // request outstanding, waiting for imem_ready
    HOLD = 2'd2   // word held for decode/execute, waiting for instr_done
  } state_t;

  state_t state;
  state_t state_next;

  // Handshake strobes produced by the FSM and consumed by the datapath.
  logic capture;   // imem_rdata is accepted this cycle
  logic advance;   // held instruction retires this cycle, PC moves on

  // Next-PC datapath signals.
  logic        is_jr;
  logic        is_jump;
  logic        branch_taken;
  logic        jr_misaligned;
  logic [31:0] jr_target;
  logic [31:0] jump_target;
  logic [31:0] branch_offset;
  logic [31:0] branch_target;
  logic [31:0] next_pc;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------

  // State register; reset is sampled on every edge so an outstanding request
  // is abandoned as soon as reset is seen.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state and handshake decode; imem_ready outside REQ and instr_done
  // outside HOLD fall through to the defaults and are ignored.
  // NOTE: every output of this block gets a default first so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_next = state;
    imem_req   = 1'b0;
    capture    = 1'b0;
    advance    = 1'b0;
    unique case (state)
      IDLE: state_next = REQ;
      REQ: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          capture    = 1'b1;
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (instr_done) begin
          advance    = 1'b1;
          state_next = REQ;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Decode of the held word and next-PC selection
  // ---------------------------------------------------------------------------

  assign opcode    = instr[31:26];
  assign funct     = instr[5:0];
  assign imem_addr = pc;
  assign pc_plus4  = pc + 32'd4;   // wraps modulo 2^32

  assign is_jr   = (opcode == OP_SPECIAL) && (funct == FUNCT_JR);
  assign is_jump = (opcode == OP_J) || (opcode == OP_JAL);

  // Both flags may be set together; the OR is evaluated exactly as written.
  assign branch_taken = (branch_beq & alu_zero) | (branch_bne & ~alu_zero);

  assign jump_target   = {pc_plus4[31:28], instr[25:0], 2'b00};
  assign branch_offset = {{14{instr[15]}}, instr[15:0], 2'b00};
  assign branch_target = pc_plus4 + branch_offset;

`ifdef FETCH_ALIGN_CHECK_EN
  // Keep the raw register value; a misaligned one is trapped instead.
  assign jr_target     = rs_value;
  assign jr_misaligned = is_jr && (rs_value[1:0] != 2'b00);
`else
  // Without the check a jr can only land on a word boundary.
  assign jr_target     = rs_value & ~32'h0000_0003;
  assign jr_misaligned = 1'b0;
`endif

  // Next PC in priority order: trapped jr, jr, jump, taken branch, sequential.
  always_comb begin
    next_pc = pc_plus4;
    if (jr_misaligned)     next_pc = EXC_VECTOR;
    else if (is_jr)        next_pc = jr_target;
    else if (is_jump)      next_pc = jump_target;
    else if (branch_taken) next_pc = branch_target;
  end

  // ---------------------------------------------------------------------------
  // Architectural registers
  // ---------------------------------------------------------------------------

  // PC, held instruction and its valid flag; a response arriving together
  // with reset is dropped because the reset branch takes precedence.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= RESET_PC;
      instr       <= 32'h0000_0000;
      instr_valid <= 1'b0;
    end else begin
      if (capture) begin
        instr       <= imem_rdata;
        instr_valid <= 1'b1;
      end
      if (advance) begin
        pc          <= next_pc;
        instr_valid <= 1'b0;
      end
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  logic exc_pulse;

  // One-cycle exception flag for the edge that retired a misaligned jr.
  always_ff @(posedge clk) begin
    if (reset) exc_pulse <= 1'b0;
    else       exc_pulse <= advance && jr_misaligned;
  end

  assign misalign_exc = exc_pulse;

  // The exception flag never stays high for two consecutive cycles.
  a_exc_single_cycle : assert property (
    @(posedge clk) disable iff (reset) misalign_exc |=> !misalign_exc
  );
`else
  assign misalign_exc = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Protocol invariants
  // ---------------------------------------------------------------------------

  // A request that is not yet accepted stays up with an unchanged address.
  a_req_stable : assert property (
    @(posedge clk) disable iff (reset)
      (imem_req && !imem_ready) |=> (imem_req && $stable(imem_addr))
  );

  // The valid flag tracks exactly the cycles spent holding a word.
  a_valid_in_hold : assert property (
    @(posedge clk) disable iff (reset) instr_valid == (state == HOLD)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: self-checking bench for fetch_unit.
// Directed scenarios follow the fetch protocol, the next-PC rules and the
// reset/wrap corner cases; a randomized run compares every retired
// instruction against an arithmetic next-PC model kept in this file.
// Honours FETCH_ALIGN_CHECK_EN to choose the expected jr behaviour.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] EXC_VECTOR = 32'h0000_0080;

  // Instruction words used by the directed scenarios.
  localparam logic [31:0] ADDI  = 32'h2008_0005;                     // addi $t0,$0,5
  localparam logic [31:0] JR    = 32'h03E0_0008;                     // jr $ra
  localparam logic [31:0] BEQ_M = {6'd4, 5'd1, 5'd2, 16'hFFFE};      // beq, imm -2
  localparam logic [31:0] BNE_M = {6'd5, 5'd1, 5'd2, 16'hFFFE};      // bne, imm -2
  localparam logic [31:0] BEQ_1 = {6'd4, 5'd1, 5'd2, 16'h0001};      // beq, imm +1
  localparam logic [31:0] J_40  = {6'd2, 26'h000_0040};
  localparam logic [31:0] JAL_40 = {6'd3, 26'h000_0040};

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        instr_done;
  logic        branch_beq;
  logic        branch_bne;
  logic        alu_zero;
  logic [31:0] rs_value;
  logic        misalign_exc;

  int checks   = 0;
  int failures = 0;

  fetch_unit #(
    .RESET_PC  (RESET_PC),
    .EXC_VECTOR(EXC_VECTOR)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .opcode      (opcode),
    .funct       (funct),
    .instr_valid (instr_valid),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .instr_done  (instr_done),
    .branch_beq  (branch_beq),
    .branch_bne  (branch_bne),
    .alu_zero    (alu_zero),
    .rs_value    (rs_value),
    .misalign_exc(misalign_exc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Everything observed about one fetched-and-retired instruction.
  typedef struct packed {
    logic        timeout;
    logic [31:0] req_addr;
    logic        addr_stable;
    logic        early_valid;
    logic        hold_valid;
    logic        hold_req;
    logic [31:0] hold_instr;
    logic [5:0]  hold_opcode;
    logic [5:0]  hold_funct;
    logic [31:0] hold_pc;
    logic [31:0] hold_pc_plus4;
    logic [31:0] new_pc;
    logic        new_valid;
    logic        exc_now;
    logic        exc_next;
  } obs_t;

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset for two edges, release, and land in the first request cycle.
  task automatic do_reset();
    reset      = 1'b1;
    imem_ready = 1'b0;
    instr_done = 1'b0;
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  // Fetch one word with `waits` wait states, then retire it with the given
  // execute results; records observations, does no comparing.
  task automatic fetch_one(input logic [31:0] word, input int waits,
                           input logic beq, input logic bne, input logic zero,
                           input logic [31:0] rs, output obs_t o);
    int n;
    o = '0;
    n = 0;
    while (imem_req !== 1'b1 && n < 8) begin
      step();
      n++;
    end
    o.timeout     = (imem_req !== 1'b1);
    o.req_addr    = imem_addr;
    o.addr_stable = 1'b1;
    o.early_valid = (instr_valid !== 1'b0);
    for (int w = 0; w < waits; w++) begin
      imem_ready = 1'b0;
      imem_rdata = $urandom;
      instr_done = 1'b1;               // must be ignored outside HOLD
      step();
      if (imem_req !== 1'b1 || imem_addr !== o.req_addr || pc !== o.req_addr)
        o.addr_stable = 1'b0;
      if (instr_valid !== 1'b0) o.early_valid = 1'b1;
    end
    instr_done = 1'b0;
    imem_ready = 1'b1;
    imem_rdata = word;
    step();
    imem_ready      = 1'b0;
    imem_rdata      = ~word;
    o.hold_valid    = instr_valid;
    o.hold_req      = imem_req;
    o.hold_instr    = instr;
    o.hold_opcode   = opcode;
    o.hold_funct    = funct;
    o.hold_pc       = pc;
    o.hold_pc_plus4 = pc_plus4;
    branch_beq = beq;
    branch_bne = bne;
    alu_zero   = zero;
    rs_value   = rs;
    instr_done = 1'b1;
    step();
    instr_done  = 1'b0;
    branch_beq  = 1'b0;
    branch_bne  = 1'b0;
    alu_zero    = 1'b0;
    o.new_pc    = pc;
    o.new_valid = instr_valid;
    o.exc_now   = misalign_exc;
    step();
    o.exc_next  = misalign_exc;
  endtask

  // Steer the PC to an aligned address by retiring a jr.
  task automatic goto_pc(input logic [31:0] target);
    obs_t o;
    fetch_one(JR, 0, 1'b0, 1'b0, 1'b0, target, o);
  endtask

  // Reference next-PC, straight from the MIPS control-flow rules.
  function automatic logic [31:0] model_next(input logic [31:0] pc_v,
                                             input logic [31:0] word,
                                             input logic beq, input logic bne,
                                             input logic zero,
                                             input logic [31:0] rs,
                                             output logic exc);
    logic [31:0]        seq;
    logic signed [15:0] imm;
    int                 offs;
    seq = pc_v + 32'd4;
    exc = 1'b0;
    if (word[31:26] == 6'd0 && word[5:0] == 6'd8) begin
`ifdef FETCH_ALIGN_CHECK_EN
      if (rs % 4 != 0) begin
        exc = 1'b1;
        return EXC_VECTOR;
      end
      return rs;
`else
      return rs - (rs % 4);
`endif
    end
    if (word[31:26] == 6'd2 || word[31:26] == 6'd3)
      return (seq & 32'hF000_0000) + 32'(word[25:0]) * 32'd4;
    if ((beq && zero) || (bne && !zero)) begin
      imm  = word[15:0];
      offs = imm;
      return seq + 32'(offs * 4);
    end
    return seq;
  endfunction

  task automatic test_reset();
    reset      = 1'b1;
    imem_ready = 1'b1;
    imem_rdata = ADDI;
    instr_done = 1'b1;
    step();
    step();
    step();
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_req: got %b want 0", imem_req); end
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
    checks++; if (pc !== RESET_PC) begin failures++; $display("FAIL reset_pc: got %h want %h", pc, RESET_PC); end
    checks++; if (instr !== 32'h0) begin failures++; $display("FAIL reset_instr: got %h want 0", instr); end
    checks++; if (misalign_exc !== 1'b0) begin failures++; $display("FAIL reset_exc: got %b want 0", misalign_exc); end
    // Cycle 0 after release is IDLE; the request appears at cycle 1.
    reset      = 1'b0;
    imem_ready = 1'b0;
    instr_done = 1'b0;
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL idle_req: got %b want 0", imem_req); end
    step();
  endtask

  // Ready and done tied high with an addi stream: request on odd cycles.
  task automatic test_sequential();
    imem_ready = 1'b1;
    instr_done = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      imem_rdata = (c % 2 == 1) ? ADDI : 32'hDEAD_BEEF;
      checks++;
      if (imem_req !== 1'((c % 2) == 1) || instr_valid !== 1'((c % 2) == 0) ||
          pc !== 32'(4 * ((c - 1) / 2))) begin
        failures++;
        $display("FAIL seq_cycle%0d: got req=%b valid=%b pc=%h want req=%b valid=%b pc=%h",
                 c, imem_req, instr_valid, pc, (c % 2) == 1, (c % 2) == 0, 4 * ((c - 1) / 2));
      end
      if (c % 2 == 0) begin
        checks++; if (instr !== ADDI) begin failures++; $display("FAIL seq_instr%0d: got %h want %h", c, instr, ADDI); end
      end
      step();
    end
    imem_ready = 1'b0;
    instr_done = 1'b0;
  endtask

  task automatic test_wait_states();
    obs_t o;
    do_reset();
    fetch_one(ADDI, 0, 1'b0, 1'b0, 1'b0, 32'h0, o);
    fetch_one(ADDI, 3, 1'b0, 1'b0, 1'b0, 32'h0, o);
    checks++; if (o.timeout || o.req_addr !== 32'h4) begin failures++; $display("FAIL wait_addr: got %h timeout=%b want 00000004", o.req_addr, o.timeout); end
    checks++; if (o.addr_stable !== 1'b1) begin failures++; $display("FAIL wait_stable: got %b want 1", o.addr_stable); end
    checks++; if (o.early_valid !== 1'b0) begin failures++; $display("FAIL wait_early_valid: got %b want 0", o.early_valid); end
    checks++; if (o.hold_valid !== 1'b1 || o.hold_req !== 1'b0) begin failures++; $display("FAIL wait_hold: got valid=%b req=%b want 1 0", o.hold_valid, o.hold_req); end
    checks++; if (o.new_pc !== 32'h8 || o.new_valid !== 1'b0) begin failures++; $display("FAIL wait_next: got pc=%h valid=%b want 00000008 0", o.new_pc, o.new_valid); end
  endtask

  task automatic test_branches();
    obs_t o;
    do_reset();
    goto_pc(32'h10);
    fetch_one(BEQ_M, 1, 1'b1, 1'b0, 1'b1, 32'h0, o);
    checks++; if (o.hold_pc !== 32'h10 || o.new_pc !== 32'h0C) begin failures++; $display("FAIL beq_taken: got at %h next %h want at 00000010 next 0000000c", o.hold_pc, o.new_pc); end
    goto_pc(32'h10);
    fetch_one(BEQ_M, 0, 1'b1, 1'b0, 1'b0, 32'h0, o);
    checks++; if (o.new_pc !== 32'h14) begin failures++; $display("FAIL beq_not_taken: got %h want 00000014", o.new_pc); end
    goto_pc(32'h10);
    fetch_one(BNE_M, 2, 1'b0, 1'b1, 1'b0, 32'h0, o);
    checks++; if (o.new_pc !== 32'h0C) begin failures++; $display("FAIL bne_taken: got %h want 0000000c", o.new_pc); end
    goto_pc(32'h10);
    fetch_one(BNE_M, 0, 1'b0, 1'b1, 1'b1, 32'h0, o);
    checks++; if (o.new_pc !== 32'h14) begin failures++; $display("FAIL bne_not_taken: got %h want 00000014", o.new_pc); end
    goto_pc(32'h10);
    fetch_one(BEQ_M, 0, 1'b1, 1'b1, 1'b1, 32'h0, o);
    checks++; if (o.new_pc !== 32'h0C) begin failures++; $display("FAIL beq_bne_both: got %h want 0000000c", o.new_pc); end
  endtask

  task automatic test_jumps();
    obs_t o;
    goto_pc(32'h1000_0000);
    fetch_one(J_40, 0, 1'b1, 1'b0, 1'b1, 32'h0, o);
    checks++; if (o.hold_opcode !== 6'd2 || o.new_pc !== 32'h1000_0100) begin failures++; $display("FAIL j_target: got op=%h next %h want op=02 next 10000100", o.hold_opcode, o.new_pc); end
    goto_pc(32'h1000_0000);
    fetch_one(JAL_40, 1, 1'b0, 1'b0, 1'b0, 32'h0, o);
    checks++; if (o.hold_pc_plus4 !== 32'h1000_0004) begin failures++; $display("FAIL jal_link: got %h want 10000004", o.hold_pc_plus4); end
    checks++; if (o.new_pc !== 32'h1000_0100) begin failures++; $display("FAIL jal_target: got %h want 10000100", o.new_pc); end
  endtask

  task automatic test_jr();
    obs_t o;
    goto_pc(32'h0);
    fetch_one(JR, 0, 1'b0, 1'b0, 1'b0, 32'h0000_0203, o);
    checks++; if (o.hold_funct !== 6'h08 || o.hold_opcode !== 6'h00) begin failures++; $display("FAIL jr_decode: got op=%h funct=%h want 00 08", o.hold_opcode, o.hold_funct); end
`ifdef FETCH_ALIGN_CHECK_EN
    checks++; if (o.new_pc !== EXC_VECTOR) begin failures++; $display("FAIL jr_misaligned_pc: got %h want %h", o.new_pc, EXC_VECTOR); end
    checks++; if (o.exc_now !== 1'b1 || o.exc_next !== 1'b0) begin failures++; $display("FAIL jr_exc_pulse: got %b then %b want 1 then 0", o.exc_now, o.exc_next); end
`else
    checks++; if (o.new_pc !== 32'h200) begin failures++; $display("FAIL jr_masked_pc: got %h want 00000200", o.new_pc); end
    checks++; if (o.exc_now !== 1'b0 || o.exc_next !== 1'b0) begin failures++; $display("FAIL jr_exc_quiet: got %b %b want 0 0", o.exc_now, o.exc_next); end
`endif
    goto_pc(32'h40);
    fetch_one(JR, 0, 1'b1, 1'b0, 1'b1, 32'h0000_0300, o);
    checks++; if (o.new_pc !== 32'h300 || o.exc_now !== 1'b0) begin failures++; $display("FAIL jr_over_beq: got %h exc=%b want 00000300 0", o.new_pc, o.exc_now); end
  endtask

  task automatic test_reset_mid_req();
    goto_pc(32'h40);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin failures++; $display("FAIL rst_pre_req: got req=%b addr=%h want 1 00000040", imem_req, imem_addr); end
    imem_ready = 1'b1;
    imem_rdata = ADDI;
    reset      = 1'b1;
    step();
    checks++; if (instr_valid !== 1'b0 || instr !== 32'h0) begin failures++; $display("FAIL rst_drop_resp: got valid=%b instr=%h want 0 00000000", instr_valid, instr); end
    checks++; if (pc !== RESET_PC || imem_req !== 1'b0) begin failures++; $display("FAIL rst_mid_req: got pc=%h req=%b want %h 0", pc, imem_req, RESET_PC); end
    imem_ready = 1'b0;
    reset      = 1'b0;
    step();
    checks++; if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin failures++; $display("FAIL rst_restart: got req=%b addr=%h want 1 %h", imem_req, imem_addr, RESET_PC); end
  endtask

  task automatic test_wrap();
    obs_t o;
    goto_pc(32'hFFFF_FFFC);
    fetch_one(ADDI, 0, 1'b0, 1'b0, 1'b0, 32'h0, o);
    checks++; if (o.hold_pc_plus4 !== 32'h0) begin failures++; $display("FAIL wrap_plus4: got %h want 00000000", o.hold_pc_plus4); end
    checks++; if (o.new_pc !== 32'h0) begin failures++; $display("FAIL wrap_seq: got %h want 00000000", o.new_pc); end
    goto_pc(32'hFFFF_FFFC);
    fetch_one(BEQ_1, 0, 1'b1, 1'b0, 1'b1, 32'h0, o);
    checks++; if (o.new_pc !== 32'h4) begin failures++; $display("FAIL wrap_branch: got %h want 00000004", o.new_pc); end
  endtask

  // Random instruction mix, wait states and execute results against the model.
  task automatic test_random();
    obs_t        o;
    logic [31:0] model_pc;
    logic [31:0] word;
    logic [31:0] rs;
    logic [31:0] exp_pc;
    logic        exp_exc;
    logic        beq, bne, zero;
    int          waits;
    do_reset();
    model_pc = RESET_PC;
    for (int i = 0; i < 300; i++) begin
      rs = $urandom;
      if ($urandom_range(0, 1) == 0) rs[1:0] = 2'b00;
      case ($urandom_range(0, 5))
        0:       word = {6'd0, 5'($urandom), 15'($urandom), 6'd8};
        1:       word = {6'd2, 26'($urandom)};
        2:       word = {6'd3, 26'($urandom)};
        3:       word = {6'd4, 26'($urandom)};
        4:       word = {6'd5, 26'($urandom)};
        default: word = $urandom;
      endcase
      beq   = 1'($urandom_range(0, 1));
      bne   = 1'($urandom_range(0, 1));
      zero  = 1'($urandom_range(0, 1));
      waits = $urandom_range(0, 3);
      exp_pc = model_next(model_pc, word, beq, bne, zero, rs, exp_exc);
      fetch_one(word, waits, beq, bne, zero, rs, o);
      checks++; if (o.timeout || o.req_addr !== model_pc || o.addr_stable !== 1'b1) begin failures++; $display("FAIL rnd%0d_req: got addr=%h stable=%b timeout=%b want %h 1 0", i, o.req_addr, o.addr_stable, o.timeout, model_pc); end
      checks++; if (o.hold_valid !== 1'b1 || o.early_valid !== 1'b0) begin failures++; $display("FAIL rnd%0d_valid: got hold=%b early=%b want 1 0", i, o.hold_valid, o.early_valid); end
      checks++; if (o.hold_instr !== word || o.hold_opcode !== word[31:26] || o.hold_funct !== word[5:0]) begin failures++; $display("FAIL rnd%0d_instr: got %h op=%h fn=%h want %h", i, o.hold_instr, o.hold_opcode, o.hold_funct, word); end
      checks++; if (o.hold_pc !== model_pc || o.hold_pc_plus4 !== model_pc + 32'd4) begin failures++; $display("FAIL rnd%0d_pc: got %h/%h want %h/%h", i, o.hold_pc, o.hold_pc_plus4, model_pc, model_pc + 32'd4); end
      checks++; if (o.new_pc !== exp_pc || o.new_valid !== 1'b0) begin failures++; $display("FAIL rnd%0d_next: instr=%h rs=%h beq=%b bne=%b z=%b got %h want %h", i, word, rs, beq, bne, zero, o.new_pc, exp_pc); end
      checks++; if (o.exc_now !== exp_exc || o.exc_next !== 1'b0) begin failures++; $display("FAIL rnd%0d_exc: got %b then %b want %b then 0", i, o.exc_now, o.exc_next, exp_exc); end
      model_pc = exp_pc;
    end
  endtask

  initial begin
    reset      = 1'b1;
    imem_ready = 1'b0;
    imem_rdata = 32'h0;
    instr_done = 1'b0;
    branch_beq = 1'b0;
    branch_bne = 1'b0;
    alu_zero   = 1'b0;
    rs_value   = 32'h0;
    test_reset();
    test_sequential();
    test_wait_states();
    test_branches();
    test_jumps();
    test_jr();
    test_reset_mid_req();
    test_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard time limit in case the design stops responding altogether.
  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the single-cycle MIPS core; sits directly upstream of the main control decoder.
- Owns the PC and runs a request/ready handshake to instruction memory.
- Holds the fetched word and presents opcode/funct to the decoder.
- Computes the next PC from the resolved branch, jump and jr information once execute signals completion.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
- EXC_VECTOR, 32'h0000_0080, redirect target for misaligned jr; used only with the optional feature.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  32  byte address of the word requested; equals pc.
- imem_ready  in  1  memory has the word; imem_rdata is valid this cycle.
- imem_rdata  in  32  instruction word.
- instr  out  32  held instruction.
- opcode  out  6  instr[31:26], to decoder.
- funct  out  6  instr[5:0], to decoder.
- instr_valid  out  1  instr is valid and may be executed.
- pc  out  32  address of the held instruction.
- pc_plus4  out  32  pc+4; link value for jal.
- instr_done  in  1  execute has finished the held instruction; advance the PC.
- branch_beq  in  1  from decoder.
- branch_bne  in  1  from decoder.
- alu_zero  in  1  ALU zero flag for the compare.
- rs_value  in  32  register rs contents; jr target.
- misalign_exc  out  1  one-cycle pulse on a misaligned jr (optional feature only; tied 0 otherwise).

Behaviour:
- Reset values: pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, misalign_exc=0, state=IDLE.
- Reset is sampled every cycle. Asserting it mid-operation abandons any outstanding request and drops imem_req on the next edge. A memory response arriving in the same cycle as reset is discarded.
- FSM states: IDLE, REQ, HOLD.
  - IDLE -> REQ unconditionally, one cycle after reset is released.
  - REQ: imem_req=1, imem_addr=pc, held stable until imem_ready=1. On imem_ready=1: instr<=imem_rdata, instr_valid<=1, go to HOLD; imem_req is 0 from the next cycle.
  - HOLD: imem_req=0, instr_valid=1. On instr_done=1: pc<=next_pc, instr_valid<=0, go to REQ.
- instr_done outside HOLD and imem_ready outside REQ are ignored.
- Latency: a zero-wait memory gives instr_valid 1 cycle after the request cycle. Minimum cost is 2 cycles per instruction (REQ, HOLD), plus wait states.
- Decode of the held instr for next-PC selection:
  - jr: opcode=000000 and funct=001000.
  - jump: opcode=000010 (j) or 000011 (jal).
- next_pc priority: jr > jump > taken branch > sequential.
  - jr target = rs_value.
  - jump target = {pc_plus4[31:28], instr[25:0], 2'b00}.
  - taken = (branch_beq & alu_zero) | (branch_bne & ~alu_zero); target = pc_plus4 + ({{14{instr[15]}}, instr[15:0], 2'b00}).
  - otherwise pc_plus4.
- Arithmetic is 32-bit modulo 2^32: pc=32'hFFFF_FFFC gives pc_plus4=0, and branch targets wrap silently.
- Without the optional feature, a jr target has its low 2 bits forced to 00.
- Simultaneous branch_beq and branch_bne with no jump/jr: evaluate the OR expression as written.
- opcode/funct are combinational slices of instr and are valid only when instr_valid=1.

Optional Feature:
- Macro: FETCH_ALIGN_CHECK_EN.
- Defined:
  - A jr in HOLD with instr_done=1 and rs_value[1:0]!=0 loads pc<=EXC_VECTOR instead of the target.
  - misalign_exc pulses 1 for exactly the cycle after that edge.
  - An aligned jr behaves normally.
- Undefined:
  - The jr target low bits are masked to 00.
  - misalign_exc is constant 0.

Test Plan:
- Reset, then ready tied 1 and instr=addi with done each HOLD -> req at cycles 1, 3, 5; pc 0x0, 0x4, 0x8; instr_valid high on alternate cycles.
- Wait states: imem_ready low 3 cycles in REQ -> imem_addr stable at 0x4 throughout; instr_valid rises only the cycle after ready.
- beq at pc=0x10 with imm=0xFFFE: alu_zero=1 -> next pc 0x0C; alu_zero=0 -> next pc 0x14. bne with alu_zero=0 -> 0x0C.
- j instr_index=0x0000040 at pc=0x1000_0000 -> next pc 0x1000_0100. jal gives the same target, and pc_plus4=0x1000_0004 during HOLD.
- jr with rs_value=0x0000_0203:
  - feature off -> next pc 0x200.
  - feature on -> pc=0x80 and misalign_exc=1 for one cycle.
  - jr while beq inputs also active -> jr wins.
- Reset asserted during REQ with ready arriving the same cycle -> instr_valid stays 0, pc=RESET_PC; wrap case pc=0xFFFF_FFFC sequential -> next pc 0x0.
